// File: rtl/des_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// des_pkg -- DES tables, constants and bit helpers (bit 1 = MSB). Rev 1.0
// ----------------------------------------------------------------------------
package des_pkg;

  localparam int DES_BLOCK_W   = 64;
  localparam int DES_HALF_W    = 32;
  localparam int DES_SUBKEY_W  = 48;
  localparam int DES_NB_ROUNDS = 16;
  localparam int DES_KEYBUS_W  = DES_SUBKEY_W * DES_NB_ROUNDS;
  localparam int DES_UNROLL    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } des_state_e;

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  // One 64-nibble row-major table per S-box; entry 0 is the leftmost nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [1:64] des_ip(input logic [1:64] b);
    logic [1:64] o;
    for (int i = 1; i <= 64; i++) o[i] = b[IP_TBL[i-1]];
    return o;
  endfunction

  function automatic logic [1:64] des_fp(input logic [1:64] b);
    logic [1:64] o;
    for (int i = 1; i <= 64; i++) o[i] = b[FP_TBL[i-1]];
    return o;
  endfunction

  function automatic logic [1:32] des_f(input logic [1:32] r, input logic [1:48] k);
    logic [1:48]  x;
    logic [1:32]  s;
    logic [1:32]  o;
    logic [0:5]   b;
    logic [255:0] sel;
    for (int i = 1; i <= 48; i++) x[i] = r[E_TBL[i-1]] ^ k[i];
    for (int n = 0; n < 8; n++) begin
      b   = x[6*n+1 +: 6];
      // outer bits pick the row, inner four the column
      sel = SBOX[n] << {b[0], b[5], b[1:4], 2'b00};
      s[4*n+1 +: 4] = sel[255:252];
    end
    for (int i = 1; i <= 32; i++) o[i] = s[P_TBL[i-1]];
    return o;
  endfunction

  function automatic logic [1:48] des_subkey(input logic [1:768] keys, input int idx);
    logic [9:0] base;
    base = 10'(DES_SUBKEY_W * (idx - 1) + 1);
    return keys[base +: DES_SUBKEY_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_feistel_round.sv
`default_nettype none
// ----------------------------------------------------------------------------
// des_feistel_round -- one combinational DES round: L'=R, R'=L^f(R,K). Rev 1.0
// ----------------------------------------------------------------------------
module des_feistel_round
  import des_pkg::*;
(
  input  logic [1:32] l_i,
  input  logic [1:32] r_i,
  input  logic [1:48] k_i,
  output logic [1:32] l_o,
  output logic [1:32] r_o
);

  assign l_o = r_i;
  assign r_o = l_i ^ des_f(r_i, k_i);

endmodule
`default_nettype wire

// File: rtl/des_decryption_unroll4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// des_decryption_unroll4 -- iterative DES decrypt, 4 rounds/clock. Rev 1.0
// ----------------------------------------------------------------------------
module des_decryption_unroll4
  import des_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:64]  message,
  input  logic [1:768] round_keys,
  output logic         done,
  output logic [1:64]  result
);

  des_state_e   state_q;
  logic [1:0]   cnt_q;
  logic [1:32]  l_q, r_q;
  logic [1:768] keys_q;
  logic         done_q;
  logic [1:64]  result_q;

  logic [1:48]  rk [0:3];
  logic [1:32]  l1, r1, l2, r2, l3, r3, l4, r4;

  // Keys are walked from K16 downwards: cycle c uses K(16-4c) .. K(13-4c).
  always_comb begin
    for (int j = 0; j < DES_UNROLL; j++) begin
      rk[j] = des_subkey(keys_q, DES_NB_ROUNDS - DES_UNROLL * int'(cnt_q) - j);
    end
  end

  des_feistel_round u_round0 (.l_i(l_q), .r_i(r_q), .k_i(rk[0]), .l_o(l1), .r_o(r1));
  des_feistel_round u_round1 (.l_i(l1),  .r_i(r1),  .k_i(rk[1]), .l_o(l2), .r_o(r2));
  des_feistel_round u_round2 (.l_i(l2),  .r_i(r2),  .k_i(rk[2]), .l_o(l3), .r_o(r3));
  des_feistel_round u_round3 (.l_i(l3),  .r_i(r3),  .k_i(rk[3]), .l_o(l4), .r_o(r4));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      l_q      <= '0;
      r_q      <= '0;
      keys_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            keys_q     <= round_keys;
            {l_q, r_q} <= des_ip(message);
            cnt_q      <= 2'd0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          l_q   <= l4;
          r_q   <= r4;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // halves are swapped back before the final permutation
            result_q <= des_fp({r4, l4});
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: doc/des_decryption_unroll4.md
Name: des_decryption_unroll4

Overview:
- Iterative DES decryption core that performs 4 Feistel rounds per clock, so one 64-bit block takes 4 round cycles.
- It is the inverse counterpart of des_encryption_unroll4. It accepts the same 768-bit encryption-order round-key bus and the same start/done handshake.
- Round keys are consumed internally in reverse order (K16 first).
- It sits beside the encryption core in the DES datapath and is driven by the same key-schedule source and benches.

Parameters:
- None. The unroll factor is fixed at 4. The block width (64) and key-bus width (768 = 16 x 48) are fixed by DES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- start  input  1  request; sampled only in IDLE
- message  input  64 [1:64]  ciphertext block; DES bit 1 = MSB; sampled with start
- round_keys  input  768 [1:768]  K1 at [1:48] through K16 at [721:768], encryption order; sampled with start
- done  output  1  one-cycle pulse; result valid
- result  output  64 [1:64]  recovered plaintext; holds until the next accepted start

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, round counter=0, done=0, result=64'h0, L/R registers=0, latched keys=0.
  - Reset wins over every other input, including mid-operation; any in-flight block is discarded with no done.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 → latch round_keys.
  - Load {L,R} = IP(message).
  - cnt=0; go to RUN.
  - start=0 → stay IDLE.
- RUN: cycle index cnt=0..3.
  - Each edge applies 4 rounds with keys K(16-4cnt), K(15-4cnt), K(14-4cnt), K(13-4cnt), in that order.
  - Each round computes L'=R, R'=L xor f(R,K).
  - cnt increments modulo 4.
- RUN with cnt=3 (edge E4):
  - result <= FP({R16,L16}), using the final swap.
  - done <= 1; go to DONE.
- DONE:
  - At edge E5: done <= 0; go to IDLE. result unchanged.
- Latency and throughput:
  - start sampled at E0; done=1 during the cycle after E4, i.e. 4 cycles start-to-done.
  - Next start is accepted at E6 at the earliest, giving 6 cycles per block back-to-back.
- start while in RUN or DONE is ignored (no queueing). message and round_keys may change freely after E0.
- A start held high continuously restarts on each IDLE visit, giving one block per 6 cycles.
- f(R,K) = P(S(E(R) xor K)) using the standard 8 S-boxes.
- Arithmetic: all XOR, no carries. Widths are exact; no truncation anywhere.
- done is never high for more than 1 cycle, and is never high in IDLE or RUN.

Decomposition:
- Shared package des_pkg holds:
  - IP, FP, E, P permutation tables.
  - S-box tables S1–S8.
  - Constants DES_BLOCK_W=64, DES_SUBKEY_W=48, DES_NB_ROUNDS=16.
  - Key slice helper: subkey i = round_keys[48(i-1)+1 : 48i].
- One natural sub-module: des_feistel_round (inputs L, R, K; outputs L', R'; combinational). It is shared with the encryption core and instantiated 4x in a chain.
- The top level owns the FSM, counter, key mux (reverse order) and IP/FP.

Test Plan:
- Classic vector:
  - Key 133457799BBCDFF1, whose schedule has K1=1B02EFFC7072 and K16=CB3D8B0E17F5.
  - message=85E813540F0AB405, pulse start → done after 4 cycles, result=0123456789ABCDEF.
- Zero key:
  - All-zero round_keys, message=8CA64DE9C1B123A7 → result=0000000000000000.
- File sweep: read the DES test file with the same fields (round_keys, plaintext, ciphertext).
  - Drive the ciphertext as message → result equals the plaintext for every line.
  - Print the correct/total count; the required pass rate is 100%.
- Ignored start:
  - Assert start again at E2 with a different message/keys → done still at E4 with the original block's plaintext.
  - Exactly one done pulse; new block not processed.
- Reset mid-operation:
  - Drop rst_n at E2 → at the next edge done=0, result=0, state IDLE; no done pulse follows.
  - A subsequent start decrypts correctly.
- Round-trip: feed des_encryption_unroll4 output into this block with the identical round_keys → result equals the original message.
  - Random 1000 blocks/keys; done is a single-cycle pulse each time.
